// File: rtl/add8_chain_seq.sv
// Multi-byte sequential adder controller that drives an external 8-bit adder one slice per cycle, LSB first.
// Optional subtract support (op_sub port) is enabled by defining ADD_SEQ_SUB_EN.
module add8_chain_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   op_a,
    input  logic [8*NBYTES-1:0]   op_b,
    input  logic                  op_cin,
`ifdef ADD_SEQ_SUB_EN
    input  logic                  op_sub,
`endif
    output logic [7:0]            add_a,
    output logic [7:0]            add_b,
    output logic                  add_cin,
    input  logic [7:0]            add_sum,
    input  logic                  add_cout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   out_sum,
    output logic                  out_cout,
    output logic                  out_ovf,
    output logic                  out_zero
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-9:0]    r_sum;
    logic            r_carry;
    logic            r_sub;
    logic [IW-1:0]   r_idx;
    logic            w_sub_in;
    logic [W-1:0]    w_sum_full;
    logic [W-1:0]    r_out_sum;
    logic            r_out_cout;
    logic            r_out_ovf;
    logic            r_out_zero;

`ifdef ADD_SEQ_SUB_EN
    assign w_sub_in = op_sub;
`else
    assign w_sub_in = 1'b0;
`endif

    // The MSB slice never lands in r_sum; it is merged straight from the adder on the final edge.
    assign w_sum_full = {add_sum, r_sum};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        add_a    = '0;
        add_b    = '0;
        add_cin  = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = RUN;
            end
            RUN: begin
                add_a   = r_a[{r_idx, 3'b000} +: 8];
                add_b   = r_b[{r_idx, 3'b000} +: 8] ^ {8{r_sub}};
                add_cin = r_carry;
                if (r_idx == LAST) w_next = DONE;
            end
            DONE: begin
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_sum      <= '0;
            r_carry    <= 1'b0;
            r_sub      <= 1'b0;
            r_idx      <= '0;
            r_out_sum  <= '0;
            r_out_cout <= 1'b0;
            r_out_ovf  <= 1'b0;
            r_out_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= op_a;
                        r_b     <= op_b;
                        r_sub   <= w_sub_in;
                        r_carry <= w_sub_in | op_cin;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_carry <= add_cout;
                    if (r_idx == LAST) begin
                        r_out_sum  <= w_sum_full;
                        r_out_cout <= add_cout;
                        r_out_ovf  <= (r_a[W-1] == add_b[7]) && (add_sum[7] != r_a[W-1]);
                        r_out_zero <= (w_sum_full == '0);
                    end else begin
                        r_sum[{r_idx, 3'b000} +: 8] <= add_sum;
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = (r_state == DONE);
    assign out_sum   = r_out_sum;
    assign out_cout  = r_out_cout;
    assign out_ovf   = r_out_ovf;
    assign out_zero  = r_out_zero;

endmodule

// File: tb/tb_add8_chain_seq.sv
// Self-checking bench for add8_chain_seq with a behavioural 8-bit adder and a whole-word scoreboard model.
// Build with ADD_SEQ_SUB_EN defined to also exercise subtraction.
module tb_add8_chain_seq;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          op_cin;
`ifdef ADD_SEQ_SUB_EN
    logic          op_sub;
`endif
    logic [7:0]    add_a;
    logic [7:0]    add_b;
    logic          add_cin;
    logic [7:0]    add_sum;
    logic          add_cout;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_cout;
    logic          out_ovf;
    logic          out_zero;

    always #5 clk = ~clk;

    add8_chain_seq #(.NBYTES(NBYTES)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
`ifdef ADD_SEQ_SUB_EN
        .op_sub(op_sub),
`endif
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
    );

    // External full_add_8bit stand-in
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int           got_lat;
    logic [W-1:0] got_sum, got_as, got_bs;
    logic         got_cout, got_ovf, got_zero;
    logic [15:0]  got_cins;
    logic [16:0]  got_done_add;
    logic         got_ready_after, got_valid_after;

    function automatic exp_t model(input logic [W-1:0] a, b, input logic cin, sub);
        logic [W-1:0] be;
        logic [W:0]   t;
        exp_t         e;
        be     = sub ? ~b : b;
        t      = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sub | cin)};
        e.sum  = t[W-1:0];
        e.cout = t[W];
        e.ovf  = (a[W-1] == be[W-1]) && (t[W-1] != a[W-1]);
        e.zero = (t[W-1:0] == '0);
        return e;
    endfunction

    function automatic logic [15:0] exp_cins(input logic [W-1:0] a, b, input logic cin, sub);
        logic [W-1:0] be, mask;
        logic [W:0]   t;
        logic [15:0]  r;
        be = sub ? ~b : b;
        r  = '0;
        r[0] = sub | cin;
        for (int k = 1; k < NBYTES; k++) begin
            mask = {W{1'b1}} >> (W - 8 * k);
            t    = {1'b0, a & mask} + {1'b0, be & mask} + {{W{1'b0}}, (sub | cin)};
            r[k] = t[8 * k];
        end
        return r;
    endfunction

    task automatic start_op(input logic [W-1:0] a, b, input logic cin, sub);
        @(negedge clk);
        op_a = a; op_b = b; op_cin = cin; in_valid = 1'b1;
`ifdef ADD_SEQ_SUB_EN
        op_sub = sub;
`endif
        sb.push_back(model(a, b, cin, sub));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        op_a = $urandom; op_b = $urandom; op_cin = ~op_cin;
        got_lat = 0; got_cins = '0; got_as = '0; got_bs = '0;
        while (!out_valid && got_lat < 50) begin
            if (got_lat < NBYTES) begin
                got_cins[got_lat]        = add_cin;
                got_as[8 * got_lat +: 8] = add_a;
                got_bs[8 * got_lat +: 8] = add_b;
            end
            @(posedge clk);
            @(negedge clk);
            got_lat++;
        end
        got_sum = out_sum; got_cout = out_cout; got_ovf = out_ovf; got_zero = out_zero;
        got_done_add = {add_a, add_b, add_cin};
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        got_ready_after = in_ready;
        got_valid_after = out_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; op_cin = 1'b0;
`ifdef ADD_SEQ_SUB_EN
        op_sub = 1'b0;
`endif
        repeat (2) @(negedge clk);
        n_checks += 6;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        if (out_sum !== '0) begin n_fail++; $display("FAIL reset_out_sum got %h exp 0", out_sum); end
        if ({out_cout, out_ovf, out_zero} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {out_cout, out_ovf, out_zero}); end
        if ({add_a, add_b, add_cin} !== 17'h0) begin n_fail++; $display("FAIL reset_add_bus got %h exp 0", {add_a, add_b, add_cin}); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_add_vectors();
        logic [W-1:0] ta[4] = '{32'h000000FF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};
        logic [W-1:0] tb[4] = '{32'h00000001, 32'h00000001, 32'h00000001, 32'hFFFFFFFF};
        logic         tc[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] ts[4] = '{32'h00000100, 32'h00000000, 32'h80000000, 32'h80000000};
        logic [2:0]   tf[4] = '{3'b000, 3'b101, 3'b010, 3'b100};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            start_op(ta[i], tb[i], tc[i], 1'b0);
            e = sb.pop_front();
            n_checks += 6;
            if (got_lat !== NBYTES) begin n_fail++; $display("FAIL vec%0d_latency got %0d exp %0d", i, got_lat, NBYTES); end
            if (got_sum !== ts[i] || got_sum !== e.sum) begin n_fail++; $display("FAIL vec%0d_sum got %h exp %h", i, got_sum, ts[i]); end
            if ({got_cout, got_ovf, got_zero} !== tf[i]) begin n_fail++; $display("FAIL vec%0d_flags got %b exp %b", i, {got_cout, got_ovf, got_zero}, tf[i]); end
            if (got_cins[NBYTES-1:0] !== exp_cins(ta[i], tb[i], tc[i], 1'b0)) begin n_fail++; $display("FAIL vec%0d_cin_trace got %b exp %b", i, got_cins[NBYTES-1:0], exp_cins(ta[i], tb[i], tc[i], 1'b0)); end
            if (got_as !== ta[i] || got_bs !== tb[i]) begin n_fail++; $display("FAIL vec%0d_slices got %h/%h exp %h/%h", i, got_as, got_bs, ta[i], tb[i]); end
            if (got_done_add !== 17'h0) begin n_fail++; $display("FAIL vec%0d_done_add_bus got %h exp 0", i, got_done_add); end
            if (i == 1) begin
                n_checks++;
                if (got_cins[3:0] !== 4'b1110) begin n_fail++; $display("FAIL vec1_cin_0111 got %b exp 1110", got_cins[3:0]); end
            end
            finish_op();
            n_checks += 2;
            if (got_ready_after !== 1'b1 || got_valid_after !== 1'b0) begin n_fail++; $display("FAIL vec%0d_return_idle got rdy=%b vld=%b exp rdy=1 vld=0", i, got_ready_after, got_valid_after); end
            if (out_sum !== ts[i]) begin n_fail++; $display("FAIL vec%0d_sum_hold got %h exp %h", i, out_sum, ts[i]); end
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        start_op(32'h12345678, 32'h11111111, 1'b0, 1'b0);
        e = sb.pop_front();
        // New operand offered while DONE must be ignored
        in_valid = 1'b1; op_a = 32'hDEADBEEF; op_b = 32'h1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks += 3;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp%0d_out_valid got %b exp 1", c, out_valid); end
            if (out_sum !== e.sum || out_sum !== 32'h23456789) begin n_fail++; $display("FAIL bp%0d_out_sum got %h exp 23456789", c, out_sum); end
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp%0d_in_ready got %b exp 0", c, in_ready); end
        end
        finish_op();
        n_checks++;
        if (got_ready_after !== 1'b1 || got_valid_after !== 1'b0) begin n_fail++; $display("FAIL bp_release got rdy=%b vld=%b exp rdy=1 vld=0", got_ready_after, got_valid_after); end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        exp_t e;
        @(negedge clk);
        op_a = 32'h11223344; op_b = 32'h01010101; op_cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (add_a !== 8'h22 || add_b !== 8'h01) begin n_fail++; $display("FAIL mid_run_slice2 got %h/%h exp 22/01", add_a, add_b); end
        rst_n = 1'b0;
        #1;
        n_checks += 2;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_state got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready); end
        if ({add_a, add_b, add_cin} !== 17'h0) begin n_fail++; $display("FAIL mid_reset_add_bus got %h exp 0", {add_a, add_b, add_cin}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (NBYTES + 2) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_no_pulse got %b exp 0", out_valid); end
        end
        start_op(32'h1, 32'h2, 1'b0, 1'b0);
        e = sb.pop_front();
        n_checks += 2;
        if (got_sum !== 32'h3 || got_sum !== e.sum) begin n_fail++; $display("FAIL after_reset_sum got %h exp 00000003", got_sum); end
        if (got_lat !== NBYTES) begin n_fail++; $display("FAIL after_reset_latency got %0d exp %0d", got_lat, NBYTES); end
        finish_op();
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic         cin, sub;
        exp_t         e;
        for (int i = 0; i < 16; i++) begin
            a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
`ifdef ADD_SEQ_SUB_EN
            sub = 1'($urandom_range(0, 1));
`else
            sub = 1'b0;
`endif
            if (i == 0) b = ~a;
            start_op(a, b, cin, sub);
            e = sb.pop_front();
            n_checks += 4;
            if (got_lat !== NBYTES) begin n_fail++; $display("FAIL rnd%0d_latency got %0d exp %0d", i, got_lat, NBYTES); end
            if (got_sum !== e.sum) begin n_fail++; $display("FAIL rnd%0d_sum got %h exp %h", i, got_sum, e.sum); end
            if ({got_cout, got_ovf, got_zero} !== {e.cout, e.ovf, e.zero}) begin n_fail++; $display("FAIL rnd%0d_flags got %b exp %b", i, {got_cout, got_ovf, got_zero}, {e.cout, e.ovf, e.zero}); end
            if (got_cins[NBYTES-1:0] !== exp_cins(a, b, cin, sub)) begin n_fail++; $display("FAIL rnd%0d_cin_trace got %b exp %b", i, got_cins[NBYTES-1:0], exp_cins(a, b, cin, sub)); end
            finish_op();
        end
    endtask

`ifdef ADD_SEQ_SUB_EN
    task automatic test_sub();
        exp_t e;
        start_op(32'd5, 32'd7, 1'b0, 1'b1);
        e = sb.pop_front();
        n_checks += 2;
        if (got_sum !== 32'hFFFFFFFE || got_sum !== e.sum) begin n_fail++; $display("FAIL sub_5_7_sum got %h exp fffffffe", got_sum); end
        if ({got_cout, got_ovf} !== 2'b00) begin n_fail++; $display("FAIL sub_5_7_flags got %b exp 00", {got_cout, got_ovf}); end
        finish_op();
        start_op(32'd7, 32'd5, 1'b0, 1'b1);
        e = sb.pop_front();
        n_checks += 3;
        if (got_sum !== 32'h2 || got_sum !== e.sum) begin n_fail++; $display("FAIL sub_7_5_sum got %h exp 00000002", got_sum); end
        if (got_cout !== 1'b1) begin n_fail++; $display("FAIL sub_7_5_cout got %b exp 1", got_cout); end
        if (got_bs !== ~32'd5) begin n_fail++; $display("FAIL sub_7_5_inverted_b got %h exp %h", got_bs, ~32'd5); end
        finish_op();
    endtask
`endif

    initial begin
        test_reset();
        test_add_vectors();
        test_backpressure();
        test_reset_mid_run();
        test_random();
`ifdef ADD_SEQ_SUB_EN
        test_sub();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout got running exp finished");
        $fatal(1, "watchdog expired");
    end

endmodule
